// File: rtl/memory_sequence_player.sv
// Memory game sequencer: grows an LFSR symbol sequence, plays it on sel, then checks button entries.
// Outputs decode from registered state (no input-to-output path); no backpressure, start/btn_valid are single-cycle pulses.
module memory_sequence_player #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 50_000_000,
    parameter int          OFF_CYCLES = 25_000_000,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         btn_valid,
    input  logic [1:0]                   btn_sym,
    output logic [1:0]                   sel,
    output logic                         blank,
    output logic                         playing,
    output logic                         awaiting,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         win,
    output logic                         fail
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_WIN,
        S_FAIL
    } state_t;

    state_t          r_state;
    logic [7:0]      r_lfsr;
    logic [LW-1:0]   r_level;
    logic [AW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_mem [MAX_LEN];

    logic            w_fb;
    logic [1:0]      w_sym;
    logic            w_last;
    logic            w_entry;
    logic            w_match;

    assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Symbol 00 means "no selection" downstream, so it is folded onto 01.
    assign w_sym   = (r_lfsr[1:0] == 2'b00) ? 2'b01 : r_lfsr[1:0];
    assign w_last  = (LW'(r_idx) == (r_level - LW'(1)));
    assign w_entry = btn_valid && (btn_sym != 2'b00);
    assign w_match = (btn_sym == r_mem[r_idx]);

    always_ff @(posedge clk) begin
        if (r_state == S_GEN) begin
            r_mem[r_level[AW-1:0]] <= w_sym;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= SEED;
            r_level <= '0;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (start) begin
                        r_level <= '0;
                        r_idx   <= '0;
                        r_state <= S_GEN;
                    end
                end
                S_GEN: begin
                    r_lfsr  <= {r_lfsr[6:0], w_fb};
                    r_level <= r_level + LW'(1);
                    r_idx   <= '0;
                    r_timer <= ON_LOAD;
                    r_state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (r_timer == '0) begin
                        r_timer <= OFF_LOAD;
                        r_state <= S_SHOW_OFF;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (r_timer == '0) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_INPUT;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_timer <= ON_LOAD;
                            r_state <= S_SHOW_ON;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_INPUT: begin
                    if (w_entry) begin
                        if (!w_match) begin
                            r_state <= S_FAIL;
                        end else if (!w_last) begin
                            r_idx <= r_idx + AW'(1);
                        end else if (r_level == LW'(MAX_LEN)) begin
                            r_state <= S_WIN;
                        end else begin
                            r_state <= S_GEN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sel      = (r_state == S_SHOW_ON) ? r_mem[r_idx] : 2'b00;
    assign blank    = (r_state != S_SHOW_ON);
    assign playing  = (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF);
    assign awaiting = (r_state == S_INPUT);
    assign level    = r_level;
    assign win      = (r_state == S_WIN);
    assign fail     = (r_state == S_FAIL);

endmodule

// File: tb/tb_memory_sequence_player.sv
// Bench for memory_sequence_player: sequence-level reference model compared every cycle, plus literal spot checks.
module tb_memory_sequence_player;

    localparam int         MAX_LEN = 4;
    localparam int         ON      = 4;
    localparam int         OFF     = 2;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         LW      = $clog2(MAX_LEN + 1);

    localparam int M_IDLE  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_INPUT = 2;
    localparam int M_WIN   = 3;
    localparam int M_FAIL  = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          btn_valid = 1'b0;
    logic [1:0]    btn_sym   = 2'b00;
    logic [1:0]    sel;
    logic          blank;
    logic          playing;
    logic          awaiting;
    logic [LW-1:0] level;
    logic          win;
    logic          fail;

    memory_sequence_player #(
        .MAX_LEN   (MAX_LEN),
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .SEED      (SEED)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .btn_valid(btn_valid),
        .btn_sym  (btn_sym),
        .sel      (sel),
        .blank    (blank),
        .playing  (playing),
        .awaiting (awaiting),
        .level    (level),
        .win      (win),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: the sequence itself plus a per-cycle timeline of the display for the current round.
    typedef struct packed {
        logic [1:0] sel;
        logic       blank;
        logic       play;
        logic [7:0] lvl;
    } tl_t;

    int         m_mode = M_IDLE;
    int         m_seq[$];
    int         m_pos  = 0;
    logic [7:0] m_lfsr = SEED;
    tl_t        m_tl[$];

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int sym_of(input logic [7:0] l);
        return (l[1:0] == 2'b00) ? 1 : int'(l[1:0]);
    endfunction

    task automatic m_new_round();
        tl_t e;
        e.sel = 2'b00; e.blank = 1'b1; e.play = 1'b0; e.lvl = 8'(m_seq.size());
        m_tl.push_back(e);
        m_seq.push_back(sym_of(m_lfsr));
        m_lfsr = lfsr_step(m_lfsr);
        foreach (m_seq[k]) begin
            repeat (ON) begin
                e.sel = 2'(m_seq[k]); e.blank = 1'b0; e.play = 1'b1; e.lvl = 8'(m_seq.size());
                m_tl.push_back(e);
            end
            repeat (OFF) begin
                e.sel = 2'b00; e.blank = 1'b1; e.play = 1'b1; e.lvl = 8'(m_seq.size());
                m_tl.push_back(e);
            end
        end
        m_mode = M_BUSY;
        m_pos  = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_mode = M_IDLE;
            m_seq.delete();
            m_tl.delete();
            m_lfsr = SEED;
            m_pos  = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_WIN, M_FAIL: begin
                    if (start) begin
                        m_seq.delete();
                        m_new_round();
                    end
                end
                M_BUSY: begin
                    m_tl.delete(0);
                    if (m_tl.size() == 0) begin
                        m_mode = M_INPUT;
                        m_pos  = 0;
                    end
                end
                M_INPUT: begin
                    if (btn_valid && btn_sym != 2'b00) begin
                        if (int'(btn_sym) != m_seq[m_pos]) m_mode = M_FAIL;
                        else if (m_pos < m_seq.size() - 1) m_pos++;
                        else if (m_seq.size() == MAX_LEN) m_mode = M_WIN;
                        else m_new_round();
                    end
                end
                default: ;
            endcase
        end
    end

    logic [1:0]    e_sel;
    logic          e_blank, e_play, e_await, e_win, e_fail;
    logic [LW-1:0] e_lvl;
    logic [9:0]    exp_v, act_v;

    initial forever begin
        @(negedge clk);
        if (m_mode == M_BUSY) begin
            e_sel = m_tl[0].sel; e_blank = m_tl[0].blank; e_play = m_tl[0].play;
            e_lvl = m_tl[0].lvl[LW-1:0]; e_await = 1'b0; e_win = 1'b0; e_fail = 1'b0;
        end else begin
            e_sel = 2'b00; e_blank = 1'b1; e_play = 1'b0; e_lvl = LW'(m_seq.size());
            e_await = (m_mode == M_INPUT); e_win = (m_mode == M_WIN); e_fail = (m_mode == M_FAIL);
        end
        exp_v = {e_sel, e_blank, e_play, e_await, e_lvl, e_win, e_fail};
        act_v = {sel, blank, playing, awaiting, level, win, fail};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle t=%0t: got %b expected %b (sel,blank,playing,awaiting,level,win,fail)",
                      $time, act_v, exp_v);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives junk on start/btn while the player is busy; every bit of it must be ignored.
    task automatic wait_await(input int budget);
        int n = 0;
        while (!awaiting && n < budget) begin
            start     = 1'($urandom_range(0, 1));
            btn_valid = 1'($urandom_range(0, 1));
            btn_sym   = 2'($urandom);
            tick();
            n++;
        end
        start     = 1'b0;
        btn_valid = 1'b0;
        check("await_reached", awaiting, 1);
    endtask

    task automatic enter(input int sym);
        repeat ($urandom_range(0, 2)) begin
            start     = 1'($urandom_range(0, 1));
            btn_valid = 1'b1;
            btn_sym   = 2'b00;
            tick();
        end
        start     = 1'($urandom_range(0, 1));
        btn_valid = 1'b1;
        btn_sym   = 2'(sym);
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        btn_sym   = 2'($urandom);
    endtask

    task automatic play_round_correct();
        int s[$];
        wait_await(200);
        s = m_seq;
        foreach (s[k]) enter(s[k]);
    endtask

    initial begin
        int s[$];
        int w;
        bit done;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) tick();
        check("idle_sel", sel, 0);
        check("idle_blank", blank, 1);
        check("idle_level", level, 0);
        check("idle_flags", {playing, awaiting, win, fail}, 0);

        // First round: GEN for one cycle, then 01 shown ON cycles, gap OFF cycles, then input.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("gen_playing", playing, 0);
        check("gen_level", level, 0);
        for (int i = 0; i < ON; i++) begin
            tick();
            check("r1_on_sel", sel, 1);
        end
        check("r1_level", level, 1);
        for (int i = 0; i < OFF; i++) begin
            tick();
            check("r1_off", {sel, blank, playing}, 3'b011);
        end
        tick();
        check("r1_awaiting", awaiting, 1);

        enter(1);
        check("r2_gen_level", level, 1);
        check("model_r2_sym", m_seq[1], 2);
        wait_await(100);
        check("r2_level", level, 2);
        enter(1);
        enter(2);
        check("model_r3_sym", m_seq[2], 1);
        check("model_lfsr_after3", m_lfsr, 8'h2A);
        wait_await(100);

        // Wrong second entry fails and the FSM stays in FAIL.
        enter(1);
        enter(3);
        check("fail_set", fail, 1);
        repeat (5) tick();
        check("fail_hold", {fail, level}, {1'b1, LW'(3)});

        // Restart with a simultaneous button: start wins, LFSR continues (2A -> symbol 10).
        start     = 1'b1;
        btn_valid = 1'b1;
        btn_sym   = 2'b01;
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        check("restart_gen", {fail, level}, 0);
        tick();
        check("restart_level", level, 1);
        check("no_reseed_sel", sel, 2);

        for (int r = 0; r < MAX_LEN; r++) play_round_correct();
        check("win_set", win, 1);
        check("win_level", level, MAX_LEN);
        repeat (6) begin
            btn_valid = 1'b1;
            btn_sym   = 2'($urandom_range(1, 3));
            tick();
        end
        btn_valid = 1'b0;
        check("win_hold", {win, playing, level}, {1'b1, 1'b0, LW'(MAX_LEN)});

        // Random games with occasional wrong entries.
        for (int g = 0; g < 3; g++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            done  = 1'b0;
            for (int r = 0; r < 2 * MAX_LEN && !done; r++) begin
                wait_await(200);
                s = m_seq;
                foreach (s[k]) begin
                    w = s[k];
                    if ($urandom_range(0, 7) == 0) w = (s[k] % 3) + 1;
                    enter(w);
                    if (fail || win) begin
                        done = 1'b1;
                        break;
                    end
                end
            end
            check("game_ended", fail | win, 1);
        end

        // Reset in the middle of SHOW_ON.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_show", {playing, blank}, 2'b10);
        reset = 1'b1;
        #1;
        check("async_reset", {sel, blank, playing, level}, {2'b00, 1'b1, 1'b0, LW'(0)});
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", {sel, blank, playing, awaiting, win, fail}, 7'b0010000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("reseed_sel", sel, 1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
